aes_inv_cipher: RTL and testbench

Iterative AES-128 inverse cipher (decryption) core that runs one round per clock. It takes a 128-bit ciphertext block over a valid/ready handshake and drives a round-key index to an external key store that holds the unmodified forward key schedule. It returns the plaintext over a second valid/ready handshake. It is the decrypt-side counterpart of the forward cipher core and sits between the block-input FIFO and the key-expansion round-key store.

---
 rtl/aes_inv_cipher_if.sv | 24 ++
 rtl/aes_inv_cipher.sv | 130 +++++++++++++
 tb/tb_aes_inv_cipher.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_if.sv
// Block-in / plaintext-out handshakes plus the round-key lookup port of the
// AES-128 inverse cipher core.
interface aes_inv_cipher_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  // Core side
  modport slave (
    input  in_valid, in_data, round_key, out_ready,
    output in_ready, key_idx, out_valid, out_data
  );

  // Environment side: block source, key store and plaintext consumer
  modport master (
    output in_valid, in_data, round_key, out_ready,
    input  in_ready, key_idx, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher, one round per clock. The standard inverse
// ordering is used, so the external key store holds the forward schedule
// as is.
module aes_inv_cipher #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       reset,
  aes_inv_cipher_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  localparam logic [3:0] NR4 = 4'(NR);

  state_e       state_q;
  logic [3:0]   r_q;
  logic [127:0] stm_q;
  logic         out_valid_q;
  logic [127:0] out_data_q;

  logic [127:0] isr, isb;
  logic [127:0] final_d;  // next out_data in FINAL
  logic [127:0] round_d;  // next stm in ROUND

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] res;
    p   = gf_mul(a, a);
    res = p;
    for (int i = 2; i < 8; i++) begin
      p   = gf_mul(p, p);
      res = gf_mul(res, p);
    end
    return res;
  endfunction

  // Inverse affine map (constant 0x05) followed by the field inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[1]^b[4]^b[6], b[0]^b[3]^b[5], b[7]^b[2]^b[4], b[6]^b[1]^b[3],
         b[5]^b[0]^b[2], b[4]^b[7]^b[1], b[3]^b[6]^b[0], b[2]^b[5]^b[7]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // InvShiftRows + InvSubBytes shared by ROUND and FINAL; byte 4c+r is row r
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign isr[127-8*(4*c+r) -: 8] = stm_q[127-8*(4*((c+4-r)%4)+r) -: 8];
      assign isb[127-8*(4*c+r) -: 8] = inv_sbox(isr[127-8*(4*c+r) -: 8]);
    end
  end

  assign final_d = isb ^ bus.round_key;

  // InvMixColumns on the key-added state
  for (genvar c = 0; c < 4; c++) begin : g_imc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = final_d[127-32*c -: 8];
    assign a1 = final_d[119-32*c -: 8];
    assign a2 = final_d[111-32*c -: 8];
    assign a3 = final_d[103-32*c -: 8];
    assign round_d[127-32*c -: 8] = gf_mul(a0,8'h0e)^gf_mul(a1,8'h0b)^gf_mul(a2,8'h0d)^gf_mul(a3,8'h09);
    assign round_d[119-32*c -: 8] = gf_mul(a0,8'h09)^gf_mul(a1,8'h0e)^gf_mul(a2,8'h0b)^gf_mul(a3,8'h0d);
    assign round_d[111-32*c -: 8] = gf_mul(a0,8'h0d)^gf_mul(a1,8'h09)^gf_mul(a2,8'h0e)^gf_mul(a3,8'h0b);
    assign round_d[103-32*c -: 8] = gf_mul(a0,8'h0b)^gf_mul(a1,8'h0d)^gf_mul(a2,8'h09)^gf_mul(a3,8'h0e);
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Round-key index: last key for the initial add, counting down to 0
  always_comb begin
    bus.key_idx = NR4;
    case (state_q)
      ROUND:   bus.key_idx = r_q;
      FINAL:   bus.key_idx = 4'd0;
      default: bus.key_idx = NR4;
    endcase
  end

  // Control FSM and datapath registers; reset drops any block in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= 4'd0;
      stm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          stm_q   <= bus.in_data ^ bus.round_key;
          r_q     <= NR4 - 4'd1;
          state_q <= ROUND;
        end
        ROUND: begin
          stm_q <= round_d;
          if (r_q == 4'd1) state_q <= FINAL;
          else             r_q     <= r_q - 4'd1;
        end
        FINAL: begin
          out_data_q  <= final_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher: FIPS-197 vectors, key_idx timing,
// backpressure, busy rejection and mid-block reset, with a plaintext
// scoreboard checked on every output handshake.
module tb_aes_inv_cipher;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT_E  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_E  = 128'h6bc1bee22e409f96e93d7e117393172a;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_inv_cipher_if bus();
  aes_inv_cipher #(.NR(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [127:0] rks [0:10];
  logic [127:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  // Key store: forward schedule, combinational lookup
  always_comb bus.round_key = (bus.key_idx <= 4'd10) ? rks[bus.key_idx] : '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    logic [7:0] acc;
    v = 8'h01;
    acc = b;
    for (int e = 0; e < 254; e++) v = gmul(v, acc);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) rks[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output handshake pops the oldest expected plaintext
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("out_unexpected", bus.out_data, 128'hx);
      else                   chk("out_data", bus.out_data, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    load_key(K_C1);
    chk("rom_c1_rk10", rks[10], RK_C1);

    // Post-reset values
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_in_ready", 128'(bus.in_ready), 1);
    chk("rst_key_idx", 128'(bus.key_idx), 10);
    chk("rst_out_valid", 128'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);

    // C.1: key_idx sequence and 11-cycle latency
    bus.in_data  = CT_C1;
    bus.in_valid = 1'b1;
    exp_q.push_back(PT_C1);
    chk("c1_in_ready_t", 128'(bus.in_ready), 1);
    chk("c1_kidx_t", 128'(bus.key_idx), 10);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk("c1_kidx", 128'(bus.key_idx), 128'(10 - i));
      chk("c1_ovalid_low", 128'(bus.out_valid), 0);
      chk("c1_in_ready_low", 128'(bus.in_ready), 0);
      tick();
    end
    chk("c1_ovalid_t11", 128'(bus.out_valid), 1);
    tick();
    chk("c1_idle_in_ready", 128'(bus.in_ready), 1);
    chk("c1_idle_ovalid", 128'(bus.out_valid), 0);
    chk("c1_drained", 128'(exp_q.size()), 0);

    // App. B with 5 cycles of backpressure
    load_key(K_B);
    chk("rom_b_rk10", rks[10], RK_B);
    bus.out_ready = 1'b0;
    bus.in_data   = CT_B;
    bus.in_valid  = 1'b1;
    exp_q.push_back(PT_B);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk("bp_latency", 128'(n), 10);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ovalid", 128'(bus.out_valid), 1);
      chk("bp_odata", bus.out_data, PT_B);
      chk("bp_in_ready", 128'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_ovalid", 128'(bus.out_valid), 0);
    chk("bp_release_in_ready", 128'(bus.in_ready), 1);
    chk("bp_one_handshake", 128'(exp_q.size()), 0);

    // Busy rejection: in_valid held with a second block waiting
    bus.in_data  = CT_B;
    bus.in_valid = 1'b1;
    exp_q.push_back(PT_B);
    tick();
    bus.in_data = CT_E;
    exp_q.push_back(PT_E);
    n = 1;
    while (bus.in_ready !== 1'b1 && n < 40) begin tick(); n++; end
    chk("busy_spacing", 128'(n), 12);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
    chk("busy_drained", 128'(exp_q.size()), 0);
    tick();

    // Reset mid-block, then a clean C.1 block
    load_key(K_C1);
    bus.in_data  = CT_C1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.key_idx !== 4'd5 && n < 20) begin tick(); n++; end
    chk("mid_reach_kidx5", 128'(bus.key_idx), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_in_ready", 128'(bus.in_ready), 1);
    chk("mid_out_valid", 128'(bus.out_valid), 0);
    chk("mid_out_data", bus.out_data, 0);
    chk("mid_key_idx", 128'(bus.key_idx), 10);
    bus.in_data  = CT_C1;
    bus.in_valid = 1'b1;
    exp_q.push_back(PT_C1);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
    chk("mid_after_drained", 128'(exp_q.size()), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
